// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - streams a (start address, length) window out of a 1-cycle-latency RAM
// Reads are throttled by a credit count so the 3-entry output buffer can never overflow.
module ram_stream_reader #(
  parameter  int DATA_DEPTH = 256,
  parameter  int DATA_WIDTH = 32,
  localparam int ADDR_WIDTH = $clog2(DATA_DEPTH),
  localparam int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic                  data_valid_o,
  input  logic                  data_ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state_q;
  logic                  cmd_ready_q;
  logic                  ram_en_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  issue_cnt_q;
  logic [LEN_WIDTH-1:0]  out_cnt_q;
  logic                  done_q;

  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] mem_q [3];
  logic [1:0]            wr_ptr_q;
  logic [1:0]            rd_ptr_q;
  logic [1:0]            occ_q;
  logic [1:0]            occ_d;

  logic                  push;
  logic                  pop;
  logic [2:0]            credit_sum;
  logic                  credit;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    return (a == ADDR_WIDTH'(DATA_DEPTH - 1)) ? '0 : a + ADDR_WIDTH'(1);
  endfunction

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign push = inflight_q;
  assign pop  = data_valid_o && data_ready_i;

  always_comb begin
    occ_d = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + 2'd1;
    end else if (!push && pop) begin
      occ_d = occ_q - 2'd1;
    end
  end

  // A read issued next cycle lands two cycles later; post-edge occupancy plus the
  // read already on the RAM port must leave room for it.
  assign credit_sum = {1'b0, occ_d} + {2'b00, ram_en_q};
  assign credit     = credit_sum < 3'd3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_addr_q  <= '0;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      ram_en_q <= 1'b0;
      done_q   <= 1'b0;
      if (pop) begin
        out_cnt_q <= out_cnt_q - LEN_WIDTH'(1);
        if (out_cnt_q == LEN_WIDTH'(1)) begin
          done_q <= 1'b1;
        end
      end
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid_i && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            out_cnt_q   <= cmd_len_i;
            if (cmd_len_i == '0) begin
              state_q <= DRAIN;
              done_q  <= 1'b1;
            end else begin
              state_q     <= ISSUE;
              ram_en_q    <= 1'b1;
              ram_addr_q  <= cmd_addr_i;
              addr_q      <= next_addr(cmd_addr_i);
              issue_cnt_q <= cmd_len_i - LEN_WIDTH'(1);
            end
          end
        end
        ISSUE: begin
          if (issue_cnt_q == '0) begin
            state_q <= DRAIN;
          end else if (credit) begin
            ram_en_q    <= 1'b1;
            ram_addr_q  <= addr_q;
            addr_q      <= next_addr(addr_q);
            issue_cnt_q <= issue_cnt_q - LEN_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (out_cnt_q == '0) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      for (int i = 0; i < 3; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      inflight_q <= ram_en_q;
      occ_q      <= occ_d;
      if (push) begin
        mem_q[wr_ptr_q] <= ram_data_i;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign ram_en_o     = ram_en_q;
  assign ram_addr_o   = ram_addr_q;
  assign data_valid_o = occ_q != 2'd0;
  assign data_o       = mem_q[rd_ptr_q];
  assign last_o       = data_valid_o && (out_cnt_q == LEN_WIDTH'(1));
  assign busy_o       = state_q != IDLE;
  assign done_o       = done_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb/tb_ram_stream_reader.sv - directed scoreboard bench for ram_stream_reader
// The attached RAM model returns its own address as data (mem[i] = i).
module tb_ram_stream_reader;

  localparam int DEPTH = 256;
  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int LW    = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [AW-1:0] cmd_addr_i;
  logic [LW-1:0] cmd_len_i;
  logic          ram_en_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_data_i;
  logic          data_valid_o;
  logic          data_ready_i;
  logic [DW-1:0] data_o;
  logic          last_o;
  logic          busy_o;
  logic          done_o;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] sb_data[$];
  logic          sb_last[$];

  ram_stream_reader #(.DATA_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_len_i    (cmd_len_i),
    .ram_en_o     (ram_en_o),
    .ram_addr_o   (ram_addr_o),
    .ram_data_i   (ram_data_i),
    .data_valid_o (data_valid_o),
    .data_ready_i (data_ready_i),
    .data_o       (data_o),
    .last_o       (last_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en_o) ram_data_i <= DW'(ram_addr_o);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input int a, input int len, input bit stall);
    int ens, pops, first_pop, last_pop, done_c, dones;
    logic [DW-1:0] prev_d;
    logic prev_l, prev_stall, got;
    for (int i = 0; i < len; i++) begin
      sb_data.push_back(DW'((a + i) % DEPTH));
      sb_last.push_back(i == len - 1);
    end
    @(negedge clk);
    cmd_valid_i  = 1'b1;
    cmd_addr_i   = AW'(a);
    cmd_len_i    = LW'(len);
    data_ready_i = 1'b1;
    got = 1'b0;
    for (int w = 0; w < 50; w++) begin
      if (cmd_ready_o) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("cmd_ready_wait", got, 1);
    ens = 0; pops = 0; first_pop = -1; last_pop = -1; done_c = -1; dones = 0;
    prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
    for (int c = 1; c < DEPTH + 40 && got; c++) begin
      @(negedge clk);
      if (c == 1) cmd_valid_i = 1'b0;
      if (ram_en_o) begin
        chk("ram_addr", ram_addr_o, (a + ens) % DEPTH);
        if (ens == 0) chk("first_en_cycle", c, 1);
        ens++;
      end
      chk("credit_bound", (ens - pops) <= 3, 1);
      if (prev_stall) begin
        chk("stall_data", data_o, prev_d);
        chk("stall_last", last_o, prev_l);
      end
      data_ready_i = stall ? ((c % 4) == 0 || (c % 4) == 1) : 1'b1;
      if (data_valid_o && data_ready_i) begin
        if (sb_data.size() == 0) begin
          chk("extra_word", 1, 0);
        end else begin
          chk("data", data_o, sb_data.pop_front());
          chk("last", last_o, sb_last.pop_front());
        end
        if (first_pop < 0) first_pop = c;
        last_pop = c;
        pops++;
      end
      prev_stall = data_valid_o && !data_ready_i;
      prev_d = data_o;
      prev_l = last_o;
      if (done_o) begin
        dones++;
        if (done_c < 0) done_c = c;
      end
      if (done_c >= 0 && c == done_c + 1) begin
        chk("ready_after_done", cmd_ready_o, 1);
        chk("idle_after_done", busy_o, 0);
        break;
      end
    end
    chk("en_count", ens, len);
    chk("sb_empty", sb_data.size(), 0);
    chk("done_count", dones, 1);
    if (len == 0) chk("done_cycle", done_c, 1);
    else          chk("done_cycle", done_c, last_pop + 1);
    if (!stall && len > 0) begin
      chk("first_pop_cycle", first_pop, 3);
      chk("last_pop_cycle", last_pop, 2 + len);
    end
    sb_data.delete();
    sb_last.delete();
  endtask

  initial begin
    rst = 1'b1; cmd_valid_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0; data_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready_o, 0);
    chk("rst_ram_en", ram_en_o, 0);
    chk("rst_ram_addr", ram_addr_o, 0);
    chk("rst_valid", data_valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready_o, 1);

    do_cmd(4, 5, 1'b0);
    do_cmd(DEPTH - 2, 4, 1'b0);
    do_cmd(9, 0, 1'b0);
    do_cmd(100, 8, 1'b1);
    do_cmd(7, DEPTH, 1'b0);

    // Reset three cycles into a ten-word command.
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_addr_i = 8'd20; cmd_len_i = 9'd10; data_ready_i = 1'b1;
    chk("mid_rst_accept_ready", cmd_ready_o, 1);
    @(negedge clk); cmd_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_pre_en", ram_en_o, 1);
    chk("mid_rst_pre_busy", busy_o, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_valid", data_valid_o, 0);
    chk("mid_rst_en", ram_en_o, 0);
    chk("mid_rst_done", done_o, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mid_rst_hold_done", done_o, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_mid_rst_done", done_o, 0);
      chk("post_mid_rst_valid", data_valid_o, 0);
    end
    do_cmd(0, 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
